// File: rtl/vga_pkg.sv
// Shared 1024x768@60 timing constants, screen-region limits and small decode helpers
// used by the pixel-timing source and the draw stages.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNC   = 136;
    localparam int unsigned H_BP     = 160;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 29;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COUNT_W   = 11;
    localparam int unsigned COUNT_MAX = (1 << COUNT_W) - 1;

    // Vertical limits of the background bands shared by the draw stages.
    localparam int unsigned SKY_V_END    = 255;
    localparam int unsigned ROAD_V_START = 448;
    localparam int unsigned ROAD_V_END   = 767;
    localparam int unsigned LINE_V_START = 592;
    localparam int unsigned LINE_V_END   = 615;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
    } flags_t;

    function automatic logic in_range(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-N up-counter with enable; exposes the next count so callers can
// register decodes in lock-step with the count itself.
module wrap_counter #(
    parameter int unsigned MODULUS = 16,
    parameter int unsigned WIDTH   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             wrap
);

    logic at_last;

    assign at_last = (count == WIDTH'(MODULUS - 1));
    assign wrap    = en && at_last;

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = at_last ? '0 : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing source: counts, sync/blank flags and a per-frame strobe, all registered.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE_P = H_ACTIVE,
    parameter int unsigned H_FP_P     = H_FP,
    parameter int unsigned H_SYNC_P   = H_SYNC,
    parameter int unsigned H_BP_P     = H_BP,
    parameter int unsigned V_ACTIVE_P = V_ACTIVE,
    parameter int unsigned V_FP_P     = V_FP,
    parameter int unsigned V_SYNC_P   = V_SYNC,
    parameter int unsigned V_BP_P     = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int unsigned HT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int unsigned VT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam count_t HS_FIRST = count_t'(H_ACTIVE_P + H_FP_P);
    localparam count_t HS_LAST  = count_t'(H_ACTIVE_P + H_FP_P + H_SYNC_P - 1);
    localparam count_t VS_FIRST = count_t'(V_ACTIVE_P + V_FP_P);
    localparam count_t VS_LAST  = count_t'(V_ACTIVE_P + V_FP_P + V_SYNC_P - 1);
    localparam count_t HB_FIRST = count_t'(H_ACTIVE_P);
    localparam count_t VB_FIRST = count_t'(V_ACTIVE_P);
    localparam count_t H_LAST   = count_t'(HT - 1);
    localparam count_t V_LAST   = count_t'(VT - 1);

    generate
        if (HT > COUNT_MAX || VT > COUNT_MAX) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
        end
    endgenerate

    count_t h_nxt;
    count_t v_nxt;
    logic   h_wrap;
    logic   v_wrap;
    flags_t flags_nxt;
    flags_t flags_q;

    wrap_counter #(.MODULUS(HT), .WIDTH(COUNT_W)) u_hcnt (
        .clk       (clk),
        .reset     (reset),
        .en        (pix_en),
        .count     (hcount_out),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    wrap_counter #(.MODULUS(VT), .WIDTH(COUNT_W)) u_vcnt (
        .clk       (clk),
        .reset     (reset),
        .en        (pix_en && h_wrap),
        .count     (vcount_out),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    // Flags are decoded from the next counts so the registered flags line up with the registered counts.
    always_comb begin
        flags_nxt       = '0;
        flags_nxt.hsync = in_range(h_nxt, HS_FIRST, HS_LAST);
        flags_nxt.vsync = in_range(v_nxt, VS_FIRST, VS_LAST);
        flags_nxt.hblnk = in_range(h_nxt, HB_FIRST, H_LAST);
        flags_nxt.vblnk = in_range(v_nxt, VB_FIRST, V_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= '0;
            frame_start <= 1'b0;
        end else begin
            flags_q     <= flags_nxt;
            frame_start <= v_wrap;
        end
    end

    assign hsync_out = flags_q.hsync;
    assign vsync_out = flags_q.vsync;
    assign hblnk_out = flags_q.hblnk;
    assign vblnk_out = flags_q.vblnk;

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size instance and a reduced-timing instance share stimulus;
// expected outputs come from a count-of-enabled-pixels model.
module tb_vga_timing_gen;

    localparam int unsigned S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int unsigned S_VA = 10, S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int unsigned B_HA = 1024, B_HFP = 24, B_HS = 136, B_HBP = 160;
    localparam int unsigned B_VA = 768, B_VFP = 3, B_VS = 6, B_VBP = 29;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] b_h, b_v, s_h, s_v;
    logic b_hs, b_vs, b_hb, b_vb, b_fs;
    logic s_hs, s_vs, s_hb, s_vb, s_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] b_fc, s_fc;
    logic [15:0] qb_fc[$];
    logic [15:0] qs_fc[$];
    logic [15:0] fc_b = 16'd0, fc_s = 16'd0;
`endif

    vga_timing_gen u_big (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount_out(b_h), .vcount_out(b_v), .hsync_out(b_hs), .vsync_out(b_vs),
        .hblnk_out(b_hb), .vblnk_out(b_vb), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE_P(S_HA), .H_FP_P(S_HFP), .H_SYNC_P(S_HS), .H_BP_P(S_HBP),
        .V_ACTIVE_P(S_VA), .V_FP_P(S_VFP), .V_SYNC_P(S_VS), .V_BP_P(S_VBP)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount_out(s_h), .vcount_out(s_v), .hsync_out(s_hs), .vsync_out(s_vs),
        .hblnk_out(s_hb), .vblnk_out(s_vb), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    obs_t qb[$];
    obs_t qs[$];
    longint n = 0;
    int   exp_pulses_b = 0, exp_pulses_s = 0;
    int   got_pulses_b = 0, got_pulses_s = 0;

    // Expected outputs after n enabled pixels since reset.
    function automatic obs_t model(input longint cnt, input logic fs,
                                   input int unsigned ha, input int unsigned hfp,
                                   input int unsigned hsy, input int unsigned hbp,
                                   input int unsigned va, input int unsigned vfp,
                                   input int unsigned vsy, input int unsigned vbp);
        obs_t   o;
        longint ht, vt, h, v;
        ht = longint'(ha + hfp + hsy + hbp);
        vt = longint'(va + vfp + vsy + vbp);
        h  = cnt % ht;
        v  = (cnt / ht) % vt;
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hs = (h >= ha + hfp) && (h < ha + hfp + hsy);
        o.vs = (v >= va + vfp) && (v < va + vfp + vsy);
        o.hb = (h >= ha);
        o.vb = (v >= va);
        o.fs = fs;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                         name, $time, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.fs,
                         exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive one clock of stimulus and queue the response expected after that edge.
    task automatic step(input logic rst, input logic en);
        logic fsb, fss;
        @(negedge clk);
        reset  = rst;
        pix_en = en;
        fsb = 1'b0;
        fss = 1'b0;
        if (rst) begin
            n = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            fc_b = 16'd0;
            fc_s = 16'd0;
`endif
        end else if (en) begin
            n++;
            fsb = (n % longint'((B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP))) == 0;
            fss = (n % longint'((S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP))) == 0;
        end
        if (fsb) exp_pulses_b++;
        if (fss) exp_pulses_s++;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fsb) fc_b = fc_b + 16'd1;
        if (fss) fc_s = fc_s + 16'd1;
        qb_fc.push_back(fc_b);
        qs_fc.push_back(fc_s);
`endif
        qb.push_back(model(n, fsb, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP));
        qs.push_back(model(n, fss, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
    endtask

    always @(posedge clk) begin
        #1;
        if (qb.size() > 0) begin
            check("big", {b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_fs}, qb.pop_front());
            if (b_fs) got_pulses_b++;
        end
        if (qs.size() > 0) begin
            check("small", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs}, qs.pop_front());
            if (s_fs) got_pulses_s++;
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (qb_fc.size() > 0) check_int("big_frame_cnt", longint'(b_fc), longint'(qb_fc.pop_front()));
        if (qs_fc.size() > 0) check_int("small_frame_cnt", longint'(s_fc), longint'(qs_fc.pop_front()));
`endif
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        // Covers the first full line of the large timing plus several small frames.
        for (int i = 0; i < 2800; i++) step(1'b0, 1'b1);
        // One enabled cycle in four.
        for (int i = 0; i < 1700; i++) step(1'b0, (i % 4) == 0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_int("big_frame_pulses", longint'(got_pulses_b), longint'(exp_pulses_b));
        check_int("small_frame_pulses", longint'(got_pulses_s), longint'(exp_pulses_s));
        check_int("queues_drained", longint'(qb.size() + qs.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
